pwr_sweep_sequencer: RTL and testbench
======================================

Name: pwr_sweep_sequencer

Overview:
- Automates power-estimation runs for the replicated DUT array (one LFSR-driven 1k x 18 block RAM per lane).
- Steps the per-lane `pwr_en`/`opt_en` vectors through a fixed sweep of enable patterns. Each pattern is held for a programmable settle time, then a measurement window.
- Flags the measurement window to the external power-sampling logic.
- Sits between the host/config registers and the DUT array's `pwr_en_in`/`opt_en_in` inputs.

Parameters:
- N_DUT, 32, number of DUT lanes driven.
- CNT_W, 32, width of the settle/dwell counters and configuration inputs.
- IDX_W, $clog2(2*N_DUT+2), width of the point index.

Ports:
- clk100m  input  1  system clock; all logic on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  start-sweep request; sampled only in IDLE.
- abort  input  1  abort the sweep; takes priority over all other inputs.
- settle_cycles  input  CNT_W  settle length per point; latched at start.
- dwell_cycles  input  CNT_W  measurement length per point; latched at start.
- pwr_en_out  output  N_DUT  drives the DUT array `pwr_en_in`.
- opt_en_out  output  N_DUT  drives the DUT array `opt_en_in`.
- point_idx  output  IDX_W  index of the current sweep point.
- meas_active  output  1  high during the MEASURE phase.
- point_done  output  1  1-cycle pulse on the last MEASURE cycle of each point.
- busy  output  1  high in SETTLE and MEASURE.
- done  output  1  1-cycle pulse when the sweep completes normally.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; every output is 0; internal counters and latched configuration are 0.
- Sweep definition:
  - Points p = 0 .. 2*N_DUT+1.
  - k = p>>1: `pwr_en_out` = thermometer mask with bits [k-1:0] set (k=0 means all zero).
  - If p[0]=0, `opt_en_out`=0 (read-only). If p[0]=1, `opt_en_out`=`pwr_en_out` (read/write).
  - Total points P = 2*N_DUT+2.
- All outputs are registered; no combinational paths from input to output.
- States: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - On `start`=1 (and `abort`=0), latch S=max(settle_cycles,1) and D=max(dwell_cycles,1).
  - Set p=0 and load the point-0 masks. Next cycle the state is SETTLE, `busy`=1.
- SETTLE:
  - Lasts exactly S cycles; `meas_active`=0.
  - Then go to MEASURE.
- MEASURE:
  - Lasts exactly D cycles; `meas_active`=1.
  - `point_done`=1 on the D-th cycle only.
  - If p<P-1 on that cycle: next cycle p=p+1, new masks, state SETTLE. The masks change on the same edge as `meas_active` falls.
  - If p=P-1: next state DONE.
- DONE:
  - Exactly 1 cycle: `done`=1, `busy`=0, `meas_active`=0.
  - Masks return to 0 on entry; `point_idx` holds P-1.
  - Then IDLE.
- Latency: the `start` sample edge to the first SETTLE cycle is 1 cycle. Each point occupies exactly S+D cycles. `busy` is high for P*(S+D) cycles.
- `start` while busy or in DONE: ignored, not queued.
- Changes to `settle_cycles`/`dwell_cycles` mid-sweep have no effect.
- `abort`=1 in any state:
  - Next cycle IDLE with all outputs 0.
  - No `done`, no `point_done` on the abort edge.
  - `start` in the same cycle is ignored.
- Counters count down from S-1/D-1 to 0 and reload at each phase change. No wrap-around is possible because `settle_cycles`/`dwell_cycles` of 0 are clamped to 1.
- Reset asserted mid-sweep: outputs drop to 0 immediately (asynchronously). After rstn releases, the block waits in IDLE for a new `start`.

Test Plan:
- N_DUT=4, settle=2, dwell=3, `start` pulse:
  - `busy` is high for exactly 50 cycles; `point_done` pulses 10 times, 5 cycles apart.
  - `done` pulses once, the cycle after the last `point_done`.
- Same config, check each MEASURE window:
  - Points 0..9 show (pwr,opt) = (0000,0000), (0000,0000), (0001,0000), (0001,0001), (0011,0000), (0011,0011), ..., (1111,1111).
  - `point_idx` matches p.
- settle=0, dwell=0, N_DUT=4: treated as 1/1; `busy` high for 20 cycles; `meas_active` alternates 0,1 each cycle.
- `abort` asserted during point 5 MEASURE: next cycle all outputs 0, state IDLE, no `done`. A later `start` restarts cleanly from point 0.
- `start` re-pulsed at point 3, with `dwell_cycles` changed to 7 mid-sweep: no restart; dwell remains 3 for all points.
- rstn pulled low during point 2 SETTLE: `pwr_en_out`/`opt_en_out`/`busy` are 0 before the next clock edge; they stay 0 after release until `start`.

Source files
------------

// File: rtl/pwr_sweep_sequencer.sv
// Power-estimation sweep sequencer.
// Steps the per-lane pwr_en/opt_en masks through a fixed list of enable
// patterns. Each pattern is held for a settle phase and then a measurement
// phase, and the measurement phase is flagged to the external power sampler.
module pwr_sweep_sequencer #(
  parameter int N_DUT = 32,
  parameter int CNT_W = 32,
  parameter int IDX_W = $clog2(2*N_DUT+2)
) (
  input  logic             clk100m,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0] dwell_cycles,
  output logic [N_DUT-1:0] pwr_en_out,
  output logic [N_DUT-1:0] opt_en_out,
  output logic [IDX_W-1:0] point_idx,
  output logic             meas_active,
  output logic             point_done,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_P = IDX_W'(2*N_DUT+1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] s_lat;
  logic [CNT_W-1:0] d_lat;
  logic [CNT_W-1:0] s_in;
  logic [CNT_W-1:0] d_in;
  logic [IDX_W-1:0] nxt_p;

  // Thermometer mask with bits [k-1:0] set, where k = point >> 1.
  function automatic logic [N_DUT-1:0] thermo(input logic [IDX_W-1:0] pt);
    logic [N_DUT-1:0] m;
    logic [IDX_W-1:0] k;
    k = pt >> 1;
    m = '0;
    for (int unsigned i = 0; i < N_DUT; i++) begin
      m[i] = (i < 32'(k));
    end
    return m;
  endfunction

  // Odd points drive the optional-write enables with the same mask.
  function automatic logic [N_DUT-1:0] opt_mask(input logic [IDX_W-1:0] pt);
    return pt[0] ? thermo(pt) : '0;
  endfunction

  // Clamp zero-length phases to one cycle; next sweep point index.
  always_comb begin
    s_in  = (settle_cycles == '0) ? CNT_W'(1) : settle_cycles;
    d_in  = (dwell_cycles == '0) ? CNT_W'(1) : dwell_cycles;
    nxt_p = point_idx + IDX_W'(1);
  end

  // Sweep FSM with all outputs registered; point_done is raised on the edge
  // that enters the final MEASURE cycle so it lines up with that cycle.
  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      s_lat       <= '0;
      d_lat       <= '0;
      pwr_en_out  <= '0;
      opt_en_out  <= '0;
      point_idx   <= '0;
      meas_active <= 1'b0;
      point_done  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      cnt         <= '0;
      pwr_en_out  <= '0;
      opt_en_out  <= '0;
      point_idx   <= '0;
      meas_active <= 1'b0;
      point_done  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            s_lat       <= s_in;
            d_lat       <= d_in;
            cnt         <= s_in - CNT_W'(1);
            point_idx   <= '0;
            pwr_en_out  <= thermo('0);
            opt_en_out  <= opt_mask('0);
            meas_active <= 1'b0;
            point_done  <= 1'b0;
            busy        <= 1'b1;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            cnt         <= d_lat - CNT_W'(1);
            meas_active <= 1'b1;
            point_done  <= (d_lat == CNT_W'(1));
            state       <= MEASURE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        MEASURE: begin
          if (cnt == '0) begin
            meas_active <= 1'b0;
            point_done  <= 1'b0;
            if (point_idx == LAST_P) begin
              pwr_en_out <= '0;
              opt_en_out <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              point_idx  <= nxt_p;
              pwr_en_out <= thermo(nxt_p);
              opt_en_out <= opt_mask(nxt_p);
              cnt        <= s_lat - CNT_W'(1);
              state      <= SETTLE;
            end
          end else begin
            cnt        <= cnt - CNT_W'(1);
            point_done <= (cnt == CNT_W'(1));
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwr_sweep_sequencer.sv
// Testbench for pwr_sweep_sequencer: cycle-position model of the sweep plus
// directed scenarios with hand-computed expectations.
module tb_pwr_sweep_sequencer;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int IW = $clog2(2*N+2);
  localparam int P  = 2*N+2;

  logic          clk100m = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] settle_cycles = '0;
  logic [CW-1:0] dwell_cycles = '0;
  logic [N-1:0]  pwr_en_out;
  logic [N-1:0]  opt_en_out;
  logic [IW-1:0] point_idx;
  logic          meas_active;
  logic          point_done;
  logic          busy;
  logic          done;

  pwr_sweep_sequencer #(.N_DUT(N), .CNT_W(CW)) dut (
    .clk100m(clk100m),
    .rstn(rstn),
    .start(start),
    .abort(abort),
    .settle_cycles(settle_cycles),
    .dwell_cycles(dwell_cycles),
    .pwr_en_out(pwr_en_out),
    .opt_en_out(opt_en_out),
    .point_idx(point_idx),
    .meas_active(meas_active),
    .point_done(point_done),
    .busy(busy),
    .done(done)
  );

  always #5 clk100m = ~clk100m;

  int m_checks = 0;
  int m_fail = 0;
  int l_checks = 0;
  int l_fail = 0;

  // Model: mode 0 idle, 1 sweeping (m_c = cycles since first settle cycle), 2 done cycle.
  int m_mode = 0;
  int m_c = 0;
  int m_s = 1;
  int m_d = 1;
  int m_idx = 0;

  always @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0;
      m_c = 0;
      m_idx = 0;
    end else if (abort) begin
      m_mode = 0;
      m_idx = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_s = (settle_cycles == 0) ? 1 : int'(settle_cycles);
          m_d = (dwell_cycles == 0) ? 1 : int'(dwell_cycles);
          m_c = 0;
          m_mode = 1;
        end
        1: begin
          m_c = m_c + 1;
          if (m_c == P * (m_s + m_d)) m_mode = 2;
        end
        default: begin
          m_mode = 0;
          m_idx = P - 1;
        end
      endcase
    end
  end

  task automatic mchk(input string name, input int act, input int exp);
    m_checks++;
    if (act != exp) begin
      m_fail++;
      $display("FAIL model_%s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic lchk(input string name, input int act, input int exp);
    l_checks++;
    if (act != exp) begin
      l_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk100m) begin : cmp
    int p, r, k, eidx;
    int epw, eop, emeas, epd, ebusy, edone;
    epw = 0; eop = 0; emeas = 0; epd = 0; ebusy = 0; edone = 0;
    eidx = m_idx;
    if (m_mode == 1) begin
      p = m_c / (m_s + m_d);
      r = m_c % (m_s + m_d);
      k = p / 2;
      epw = (1 << k) - 1;
      eop = (p % 2 == 1) ? epw : 0;
      eidx = p;
      emeas = (r >= m_s) ? 1 : 0;
      epd = (r == m_s + m_d - 1) ? 1 : 0;
      ebusy = 1;
    end else if (m_mode == 2) begin
      eidx = P - 1;
      edone = 1;
    end
    mchk("pwr_en_out", int'(pwr_en_out), epw);
    mchk("opt_en_out", int'(opt_en_out), eop);
    mchk("point_idx", int'(point_idx), eidx);
    mchk("meas_active", int'(meas_active), emeas);
    mchk("point_done", int'(point_done), epd);
    mchk("busy", int'(busy), ebusy);
    mchk("done", int'(done), edone);
  end

  // Results of the most recent observed sweep.
  int nb, npd, nd, gap_bad, done_gap, alt_bad;
  logic [N-1:0] pwr_at [10];
  logic [N-1:0] opt_at [10];
  int idx_at [10];

  task automatic do_start();
    @(posedge clk100m); #2 start = 1'b1;
    @(posedge clk100m); #2 start = 1'b0;
  endtask

  // Observe one sweep from its first settle cycle; optionally re-pulse start
  // and change dwell_cycles after poke_pd point_done pulses.
  task automatic run_count(input int bound, input int gap, input int poke_pd);
    int prev, done_i, poke;
    nb = 0; npd = 0; nd = 0; gap_bad = 0; done_gap = -1; alt_bad = 0;
    prev = -1; done_i = -1; poke = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk100m);
      if (poke > 0) begin
        poke--;
        if (poke == 0) start = 1'b0;
      end
      if (busy) nb++;
      if (i < 20 && (meas_active != (i % 2 == 1))) alt_bad++;
      if (point_done) begin
        if (prev >= 0 && i - prev != gap) gap_bad++;
        if (npd < 10) begin
          pwr_at[npd] = pwr_en_out;
          opt_at[npd] = opt_en_out;
          idx_at[npd] = int'(point_idx);
        end
        prev = i;
        npd++;
        if (npd == poke_pd) begin
          start = 1'b1;
          dwell_cycles = 7;
          poke = 3;
        end
      end
      if (done) begin
        nd++;
        done_gap = i - prev;
        done_i = i;
      end
      if (done_i >= 0 && i >= done_i + 3) break;
    end
    lchk("sweep_finished", (done_i >= 0) ? 1 : 0, 1);
  endtask

  task automatic wait_point(input int pt, input int want_meas, output int ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk100m);
      if (int'(point_idx) == pt && busy && int'(meas_active) == want_meas) begin
        ok = 1;
        break;
      end
    end
    lchk("wait_point", ok, 1);
  endtask

  initial begin
    logic [N-1:0] exp_pwr [10];
    logic [N-1:0] exp_opt [10];
    int ok;
    exp_pwr = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0011,
                4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
    exp_opt = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
                4'b0011, 4'b0000, 4'b0111, 4'b0000, 4'b1111};

    // Reset state
    #1 rstn = 1'b0;
    @(negedge clk100m);
    lchk("reset_pwr", int'(pwr_en_out), 0);
    lchk("reset_busy", int'(busy), 0);
    lchk("reset_idx", int'(point_idx), 0);
    #3 rstn = 1'b1;

    // Basic sweep, settle=2 dwell=3
    settle_cycles = 2;
    dwell_cycles = 3;
    do_start();
    run_count(100, 5, -1);
    lchk("t1_busy_cycles", nb, 50);
    lchk("t1_point_done_count", npd, 10);
    lchk("t1_point_done_spacing", gap_bad, 0);
    lchk("t1_done_count", nd, 1);
    lchk("t1_done_after_last_pd", done_gap, 1);
    for (int i = 0; i < 10; i++) begin
      lchk($sformatf("t1_pwr_p%0d", i), int'(pwr_at[i]), int'(exp_pwr[i]));
      lchk($sformatf("t1_opt_p%0d", i), int'(opt_at[i]), int'(exp_opt[i]));
      lchk($sformatf("t1_idx_p%0d", i), idx_at[i], i);
    end

    // start re-pulse and dwell change mid-sweep are ignored
    dwell_cycles = 3;
    do_start();
    run_count(100, 5, 3);
    lchk("t2_busy_cycles", nb, 50);
    lchk("t2_point_done_count", npd, 10);
    lchk("t2_point_done_spacing", gap_bad, 0);
    lchk("t2_done_count", nd, 1);

    // Zero lengths clamp to one cycle each
    settle_cycles = 0;
    dwell_cycles = 0;
    do_start();
    run_count(60, 2, -1);
    lchk("t3_busy_cycles", nb, 20);
    lchk("t3_meas_alternates", alt_bad, 0);
    lchk("t3_point_done_count", npd, 10);
    lchk("t3_done_count", nd, 1);

    // Abort during point 5 MEASURE, with start in the same cycle
    settle_cycles = 2;
    dwell_cycles = 3;
    do_start();
    wait_point(5, 1, ok);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk100m);
    abort = 1'b0;
    start = 1'b0;
    lchk("abort_busy", int'(busy), 0);
    lchk("abort_pwr", int'(pwr_en_out), 0);
    lchk("abort_opt", int'(opt_en_out), 0);
    lchk("abort_meas", int'(meas_active), 0);
    lchk("abort_idx", int'(point_idx), 0);
    lchk("abort_done", int'(done), 0);
    lchk("abort_point_done", int'(point_done), 0);
    nd = 0;
    nb = 0;
    repeat (10) begin
      @(negedge clk100m);
      if (done) nd++;
      if (busy) nb++;
    end
    lchk("abort_no_done", nd, 0);
    lchk("abort_stays_idle", nb, 0);
    do_start();
    run_count(100, 5, -1);
    lchk("restart_busy_cycles", nb, 50);
    lchk("restart_pwr_p3", int'(pwr_at[3]), 1);
    lchk("restart_done_count", nd, 1);

    // Asynchronous reset during point 2 SETTLE
    do_start();
    wait_point(2, 0, ok);
    lchk("pre_reset_pwr", int'(pwr_en_out), 1);
    #3 rstn = 1'b0;
    #1;
    lchk("async_reset_pwr", int'(pwr_en_out), 0);
    lchk("async_reset_opt", int'(opt_en_out), 0);
    lchk("async_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk100m);
    #3 rstn = 1'b1;
    nb = 0;
    nd = 0;
    repeat (8) begin
      @(negedge clk100m);
      if (busy || pwr_en_out != 0 || opt_en_out != 0) nb++;
      if (done) nd++;
    end
    lchk("post_reset_idle", nb, 0);
    lchk("post_reset_no_done", nd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", m_checks + l_checks, m_fail + l_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

endmodule
